// File: rtl/rx_tlp_sender_pkg.sv
// Shared constants, state/command encodings and TLP header helpers for the rx TLP sender.
package rx_tlp_sender_pkg;

  localparam int BF             = 9;
  localparam int RD_AW          = BF + 1;
  localparam int DATA_W         = 64;
  localparam int MAX_PAYLOAD_QW = 16;
  localparam int HDR_RSVD_QW    = 16;
  localparam int PAGE_QW_BITS   = 18;
  localparam int OFS_W          = PAGE_QW_BITS + 1;

  localparam logic [2:0] MWR_FMT  = 3'b011;
  localparam logic [4:0] MWR_TYPE = 5'b00000;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_WAIT_PAGE  = 4'd1,
    S_HDR0       = 4'd2,
    S_HDR1       = 4'd3,
    S_PAYLOAD    = 4'd4,
    S_ACK_DATA   = 4'd5,
    S_CLOSE_HDR0 = 4'd6,
    S_CLOSE_HDR1 = 4'd7,
    S_CLOSE_DATA = 4'd8,
    S_ACK_PAGE   = 4'd9
  } tx_state_e;

  typedef enum logic [1:0] {
    CMD_DATA  = 2'd0,
    CMD_LAST  = 2'd1,
    CMD_CLOSE = 2'd2
  } cmd_e;

  // 4DW MWr, TC/attr/TD/EP zero.
  function automatic logic [31:0] mwr_dw0(input logic [9:0] len_dw);
    return {MWR_FMT, MWR_TYPE, 14'h0000, len_dw};
  endfunction

  function automatic logic [31:0] mwr_dw1(input logic [15:0] req_id);
    return {req_id, 8'h00, 4'hF, 4'hF};
  endfunction

endpackage

// File: rtl/rx_tlp_sender_if.sv
// 64-bit AXI-Stream TX port towards the PCIe endpoint core.
interface rx_tlp_sender_if;

  logic [63:0] s_axis_tx_tdata;
  logic [7:0]  s_axis_tx_tkeep;
  logic        s_axis_tx_tvalid;
  logic        s_axis_tx_tready;
  logic        s_axis_tx_tlast;

  modport master (
    output s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tvalid, s_axis_tx_tlast,
    input  s_axis_tx_tready
  );

  modport slave (
    input  s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tvalid, s_axis_tx_tlast,
    output s_axis_tx_tready
  );

endinterface

// File: rtl/rx_tlp_skid_buf.sv
// Two-entry FIFO that absorbs the one-cycle rx buffer read latency ahead of tdata.
module rx_tlp_skid_buf
  import rx_tlp_sender_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;

  // Storage, pointers and occupancy; the caller never pushes into a full buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_r[0] <= {DATA_W{1'b0}};
      mem_r[1] <= {DATA_W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/rx_tlp_sender.sv
// Turns rx_tlp_trigger commands into posted 4DW MWr TLPs that copy rx buffer qwords into the
// current host huge page, and closes pages by writing their qword count at page offset 0.
module rx_tlp_sender
  import rx_tlp_sender_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger_tlp,
  output logic              trigger_tlp_ack,
  input  logic              send_last_tlp,
  input  logic              change_huge_page,
  output logic              change_huge_page_ack,
  input  logic [4:0]        qwords_to_send,
  output logic [RD_AW-1:0]  rd_addr,
  input  logic [63:0]       rd_data,
  input  logic [63:0]       huge_page_addr_1,
  input  logic [63:0]       huge_page_addr_2,
  input  logic              huge_page_status_1,
  input  logic              huge_page_status_2,
  output logic              huge_page_unlock_1,
  output logic              huge_page_unlock_2,
  input  logic [15:0]       cfg_completer_id,
  rx_tlp_sender_if.master   tx
);

  tx_state_e        state_r, state_n_s;
  cmd_e             cmd_r, cmd_n_s;
  logic             accept_s;
  logic [4:0]       qw_r, reads_left_r, beat_cnt_r;
  logic             page_r, inflight_r, idle_hold_r;
  logic [OFS_W-1:0] ofs_r;
  logic [RD_AW-1:0] rd_addr_r;
  logic             trigger_tlp_ack_r, change_huge_page_ack_r, unlock_1_r, unlock_2_r;
  logic [63:0]      page_base_s, data_addr_s, tdata_s, skid_head_s;
  logic [31:0]      dw1_s;
  logic             tvalid_s, tlast_s, hs_s, pop_s, issue_s, page_ok_s, last_beat_s, rd_state_s;
  logic [1:0]       skid_count_s;
  logic [2:0]       occ_s;

  assign page_base_s = page_r ? huge_page_addr_2 : huge_page_addr_1;
  assign page_ok_s   = page_r ? huge_page_status_2 : huge_page_status_1;
  assign data_addr_s = page_base_s + {42'd0, ofs_r, 3'd0};
  assign dw1_s       = mwr_dw1(cfg_completer_id);
  assign last_beat_s = (beat_cnt_r == (qw_r - 5'd1));
  assign hs_s        = tvalid_s & tx.s_axis_tx_tready;
  assign pop_s       = (state_r == S_PAYLOAD) & hs_s;

  // Reads run ahead through the headers; a read is issued only when the skid has room for it.
  assign rd_state_s  = (state_r == S_HDR0) | (state_r == S_HDR1) | (state_r == S_PAYLOAD);
  assign occ_s       = {1'b0, skid_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign issue_s     = rd_state_s & (reads_left_r != 5'd0) & (occ_s < 3'd2);

  rx_tlp_skid_buf u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_r),
    .push_data (rd_data),
    .pop       (pop_s),
    .head_data (skid_head_s),
    .count     (skid_count_s)
  );

  // TX beat selection from the current state.
  always_comb begin
    tvalid_s = 1'b0;
    tlast_s  = 1'b0;
    tdata_s  = 64'd0;
    case (state_r)
      S_HDR0:       begin tvalid_s = 1'b1; tdata_s = {dw1_s, mwr_dw0({4'd0, qw_r, 1'b0})}; end
      S_HDR1:       begin tvalid_s = 1'b1; tdata_s = {data_addr_s[31:0], data_addr_s[63:32]}; end
      S_PAYLOAD: begin
        tvalid_s = (skid_count_s != 2'd0);
        tdata_s  = skid_head_s;
        tlast_s  = last_beat_s;
      end
      S_CLOSE_HDR0: begin tvalid_s = 1'b1; tdata_s = {dw1_s, mwr_dw0(10'd2)}; end
      S_CLOSE_HDR1: begin tvalid_s = 1'b1; tdata_s = {page_base_s[31:0], page_base_s[63:32]}; end
      S_CLOSE_DATA: begin
        tvalid_s = 1'b1;
        tlast_s  = 1'b1;
        tdata_s  = {45'd0, ofs_r - OFS_W'(HDR_RSVD_QW)};
      end
      default:      begin tvalid_s = 1'b0; end
    endcase
  end

  // Next-state and command acceptance.
  always_comb begin
    state_n_s = state_r;
    accept_s  = 1'b0;
    cmd_n_s   = cmd_r;
    case (state_r)
      S_IDLE: begin
        if (idle_hold_r) begin
          state_n_s = S_IDLE;
        end else if (trigger_tlp) begin
          accept_s  = 1'b1;
          cmd_n_s   = CMD_DATA;
          state_n_s = (qwords_to_send == 5'd0) ? S_ACK_DATA : S_WAIT_PAGE;
        end else if (send_last_tlp) begin
          accept_s  = 1'b1;
          cmd_n_s   = CMD_LAST;
          state_n_s = S_WAIT_PAGE;
        end else if (change_huge_page) begin
          accept_s  = 1'b1;
          cmd_n_s   = CMD_CLOSE;
          state_n_s = S_WAIT_PAGE;
        end else begin
          state_n_s = S_IDLE;
        end
      end
      S_WAIT_PAGE: begin
        if (!page_ok_s) begin
          state_n_s = S_WAIT_PAGE;
        end else if ((cmd_r == CMD_CLOSE) || (qw_r == 5'd0)) begin
          state_n_s = S_CLOSE_HDR0;
        end else begin
          state_n_s = S_HDR0;
        end
      end
      S_HDR0:       state_n_s = hs_s ? S_HDR1 : S_HDR0;
      S_HDR1:       state_n_s = hs_s ? S_PAYLOAD : S_HDR1;
      S_PAYLOAD: begin
        if (hs_s && last_beat_s) begin
          state_n_s = (cmd_r == CMD_LAST) ? S_CLOSE_HDR0 : S_ACK_DATA;
        end else begin
          state_n_s = S_PAYLOAD;
        end
      end
      S_CLOSE_HDR0: state_n_s = hs_s ? S_CLOSE_HDR1 : S_CLOSE_HDR0;
      S_CLOSE_HDR1: state_n_s = hs_s ? S_CLOSE_DATA : S_CLOSE_HDR1;
      S_CLOSE_DATA: state_n_s = hs_s ? S_ACK_PAGE : S_CLOSE_DATA;
      S_ACK_DATA:   state_n_s = S_IDLE;
      S_ACK_PAGE:   state_n_s = S_IDLE;
      default:      state_n_s = S_IDLE;
    endcase
  end

  // State, command context, page bookkeeping, read pointer and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r                <= S_IDLE;
      cmd_r                  <= CMD_DATA;
      qw_r                   <= 5'd0;
      reads_left_r           <= 5'd0;
      beat_cnt_r             <= 5'd0;
      page_r                 <= 1'b0;
      inflight_r             <= 1'b0;
      idle_hold_r            <= 1'b0;
      ofs_r                  <= OFS_W'(HDR_RSVD_QW);
      rd_addr_r              <= {RD_AW{1'b0}};
      trigger_tlp_ack_r      <= 1'b0;
      change_huge_page_ack_r <= 1'b0;
      unlock_1_r             <= 1'b0;
      unlock_2_r             <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      idle_hold_r <= (state_r == S_ACK_DATA) | (state_r == S_ACK_PAGE);
      inflight_r  <= issue_s;
      if (accept_s) begin
        cmd_r        <= cmd_n_s;
        qw_r         <= qwords_to_send;
        reads_left_r <= (cmd_n_s == CMD_CLOSE) ? 5'd0 : qwords_to_send;
      end else if (issue_s) begin
        reads_left_r <= reads_left_r - 5'd1;
      end
      if (issue_s) begin
        rd_addr_r <= rd_addr_r + {{(RD_AW-1){1'b0}}, 1'b1};
      end
      if (state_r == S_HDR0) begin
        beat_cnt_r <= 5'd0;
      end else if (pop_s) begin
        beat_cnt_r <= beat_cnt_r + 5'd1;
      end
      if (state_r == S_ACK_PAGE) begin
        page_r <= ~page_r;
        ofs_r  <= OFS_W'(HDR_RSVD_QW);
      end else if (pop_s && last_beat_s) begin
        ofs_r <= ofs_r + {14'd0, qw_r};
      end
      trigger_tlp_ack_r      <= (state_n_s == S_ACK_DATA);
      change_huge_page_ack_r <= (state_n_s == S_ACK_PAGE);
      unlock_1_r             <= (state_n_s == S_ACK_PAGE) & ~page_r;
      unlock_2_r             <= (state_n_s == S_ACK_PAGE) & page_r;
    end
  end

  assign trigger_tlp_ack      = trigger_tlp_ack_r;
  assign change_huge_page_ack = change_huge_page_ack_r;
  assign huge_page_unlock_1   = unlock_1_r;
  assign huge_page_unlock_2   = unlock_2_r;
  assign rd_addr              = rd_addr_r;

  assign tx.s_axis_tx_tdata  = tdata_s;
  assign tx.s_axis_tx_tvalid = tvalid_s;
  assign tx.s_axis_tx_tlast  = tlast_s;
  assign tx.s_axis_tx_tkeep  = tvalid_s ? 8'hFF : 8'h00;

endmodule
